// File: rtl/dec_lut.sv
// dec_lut: N-to-2^N decoder with registered one-hot output and a
// serially loaded minterm mask driving a single sum-of-minterms output.
module dec_lut #(
    parameter int              N         = 3,
    parameter logic [(1<<N)-1:0] INIT_MASK = 8'hE8,
    parameter int              CW        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_en,
    input  logic                cfg_bit,
    output logic                cfg_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        w,
    input  logic                e,
    output logic                out_valid,
    output logic [(1<<N)-1:0]   y,
    output logic                f,
    output logic [CW-1:0]       hits,
    input  logic                hit_clr
);

    localparam int M = 1 << N;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:0]   mask_q, mask_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           ov_q, ov_d;
    logic [M-1:0]   y_q, y_d;
    logic           f_q, f_d;
    logic [CW-1:0]  hits_q, hits_d;

    logic accept;
    logic hit;
    logic last;

    assign accept = in_valid & (state_q == RUN);
    assign hit    = accept & e & mask_q[w];
    assign last   = (cnt_q == N'(M - 1));

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ov_d    = accept;
        y_d     = '0;
        f_d     = hit;
        hits_d  = hits_q;

        if (accept && e) begin
            y_d = {{(M-1){1'b0}}, 1'b1} << w;
        end

        unique case (state_q)
            RUN: begin
                if (cfg_start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (cfg_en) begin
                    mask_d = {cfg_bit, mask_q[M-1:1]};
                    if (last) begin
                        cnt_d   = '0;
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + N'(1);
                    end
                end
            end
            default: state_d = RUN;
        endcase

        // Clear wins over a coincident hit; counter sticks at all-ones.
        if (hit_clr) begin
            hits_d = '0;
        end else if (hit && !(&hits_q)) begin
            hits_d = hits_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            mask_q  <= INIT_MASK;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            y_q     <= '0;
            f_q     <= 1'b0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ov_q    <= ov_d;
            y_q     <= y_d;
            f_q     <= f_d;
            hits_q  <= hits_d;
        end
    end

    assign in_ready  = (state_q == RUN);
    assign cfg_done  = done_q;
    assign out_valid = ov_q;
    assign y         = y_q;
    assign f         = f_q;
    assign hits      = hits_q;

endmodule
